// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter:
// index field bounds, owner encoding and the address check.
package data_mem_arbiter_pkg;

    localparam int MEM_IDX_HI = 9;
    localparam int MEM_IDX_LO = 2;
    localparam int IDX_W      = MEM_IDX_HI - MEM_IDX_LO + 1;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_P0   = 2'd1,
        OWNER_P1   = 2'd2
    } owner_t;

    // Misaligned, beyond the implemented words, or above the index field.
    function automatic logic addr_err(
        input logic [31:0] a,
        input int unsigned words
    );
        logic [IDX_W-1:0] idx;
        idx = a[MEM_IDX_HI:MEM_IDX_LO];
        return (a[1:0] != 2'b00)
            || (32'(idx) >= words)
            || (a[31:MEM_IDX_HI+1] != '0);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; a locking owner that
// still requests always wins over the rotation.
module rr_arbiter2
    import data_mem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_owner,
    input  logic       i_last_grant,
    output logic [1:0] o_gnt
);

    logic w_own0;
    logic w_own1;
    logic w_free;

    assign w_own0 = (i_owner == OWNER_P0) && i_req[0];
    assign w_own1 = (i_owner == OWNER_P1) && i_req[1];
    assign w_free = !w_own0 && !w_own1;

    // Owner first, then the port that did not win last, else the lone requester.
    always_comb begin
        o_gnt = 2'b00;
        unique case (1'b1)
            w_own0:                    o_gnt = 2'b01;
            w_own1:                    o_gnt = 2'b10;
            w_free && (&i_req):        o_gnt = i_last_grant ? 2'b01 : 2'b10;
            w_free && (i_req == 2'b01): o_gnt = 2'b01;
            w_free && (i_req == 2'b10): o_gnt = 2'b10;
            default:                   o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the load/store unit (port 0)
// and the debug/DMA loader (port 1), with short lock for RMW pairs.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int MEM_WORDS = 128,
    parameter int LOCK_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_idx,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

    owner_t           r_owner;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [1:0]       r_rvalid;
    logic [1:0]       r_err;
    logic [31:0]      r_rdata0;
    logic [31:0]      r_rdata1;

    logic [1:0]       w_arb_gnt;
    logic [1:0]       w_gnt;
    logic             w_any;
    logic             w_sel;
    logic             w_we;
    logic             w_lock;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic             w_err;
    logic [31:0]      w_rd;
    logic             w_owner_held;
    logic [CNT_W-1:0] w_cnt;

    rr_arbiter2 u_arb (
        .i_req       ({m1_req, m0_req}),
        .i_owner     (r_owner),
        .i_last_grant(r_last_grant),
        .o_gnt       (w_arb_gnt)
    );

    // Nothing is granted while reset is held, so no stray memory write.
    assign w_gnt   = rst_n ? w_arb_gnt : 2'b00;
    assign w_any   = |w_gnt;
    assign w_sel   = w_gnt[1];
    assign m0_gnt  = w_gnt[0];
    assign m1_gnt  = w_gnt[1];

    assign w_we    = w_sel ? m1_we    : m0_we;
    assign w_lock  = w_sel ? m1_lock  : m0_lock;
    assign w_addr  = w_sel ? m1_addr  : m0_addr;
    assign w_wdata = w_sel ? m1_wdata : m0_wdata;
    assign w_err   = addr_err(w_addr, MEM_WORDS);
    assign w_rd    = (w_we || w_err) ? 32'd0 : mem_read_data;

    assign mem_idx          = w_any ? w_addr  : 32'd0;
    assign mem_write_data   = w_any ? w_wdata : 32'd0;
    assign mem_write_enable = w_any && w_we && !w_err;

    // A lock count only carries over while its owner keeps requesting.
    assign w_owner_held = ((r_owner == OWNER_P0) && m0_req)
                       || ((r_owner == OWNER_P1) && m1_req);
    assign w_cnt        = w_owner_held ? r_lock_cnt : '0;

    // Ownership FSM: take or extend the lock on grant, release otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= OWNER_NONE;
            r_last_grant <= 1'b1;
            r_lock_cnt   <= '0;
        end else if (w_any) begin
            r_last_grant <= w_sel;
            if (w_lock && (w_cnt < LOCK_LAST)) begin
                r_owner    <= w_sel ? OWNER_P1 : OWNER_P0;
                r_lock_cnt <= w_cnt + 1'b1;
            end else begin
                r_owner    <= OWNER_NONE;
                r_lock_cnt <= '0;
            end
        end else begin
            r_owner    <= OWNER_NONE;
            r_lock_cnt <= '0;
        end
    end

    // Registered per-port response, one cycle after each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 2'b00;
            r_err    <= 2'b00;
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_gnt[0]) begin
                r_err[0] <= w_err;
                r_rdata0 <= w_rd;
            end
            if (w_gnt[1]) begin
                r_err[1] <= w_err;
                r_rdata1 <= w_rd;
            end
        end
    end

    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_err    = r_err[0];
    assign m1_err    = r_err[1];
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed requests push
// expected responses; a negedge monitor pops and compares them.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m0_lock = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic        m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_idx, mem_write_data, mem_read_data;
    logic        mem_write_enable;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    rsp_t        sb[$];
    rsp_t        mon_e;
    logic [1:0]  mon_ev;
    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          run = 1'b0;

    data_mem_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m0_req          (m0_req),
        .m0_we           (m0_we),
        .m0_addr         (m0_addr),
        .m0_wdata        (m0_wdata),
        .m0_lock         (m0_lock),
        .m0_gnt          (m0_gnt),
        .m0_rvalid       (m0_rvalid),
        .m0_rdata        (m0_rdata),
        .m0_err          (m0_err),
        .m1_req          (m1_req),
        .m1_we           (m1_we),
        .m1_addr         (m1_addr),
        .m1_wdata        (m1_wdata),
        .m1_lock         (m1_lock),
        .m1_gnt          (m1_gnt),
        .m1_rvalid       (m1_rvalid),
        .m1_rdata        (m1_rdata),
        .m1_err          (m1_err),
        .mem_idx         (mem_idx),
        .mem_write_data  (mem_write_data),
        .mem_write_enable(mem_write_enable),
        .mem_read_data   (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port memory: async read, write at posedge.
    assign mem_read_data = mem[mem_idx[9:2]];
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_idx[9:2]] <= mem_write_data;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic drv(input logic r0, input logic w0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic l0,
                       input logic r1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1,
                       input logic l1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_lock = l0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = l1;
    endtask

    // Called at posedge+1 with inputs driven; checks grant and queues response.
    task automatic cycle(input logic [1:0] eg, input logic ewe,
                         input logic [31:0] erd, input logic eerr);
        rsp_t e;
        @(negedge clk);
        chk("gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, eg});
        chk("mem_we", {31'd0, mem_write_enable}, {31'd0, ewe});
        if (eg != 2'b00) begin
            e.port  = eg[1];
            e.rdata = erd;
            e.err   = eerr;
            e.cyc   = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every negedge the rvalid pair must match the queue head's due cycle.
    always @(negedge clk) begin
        if (run && rst_n) begin
            mon_ev = 2'b00;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e  = sb.pop_front();
                mon_ev = mon_e.port ? 2'b10 : 2'b01;
                chk("rsp_rdata", mon_e.port ? m1_rdata : m0_rdata, mon_e.rdata);
                chk("rsp_err", {31'd0, mon_e.port ? m1_err : m0_err},
                    {31'd0, mon_e.err});
            end
            chk("rvalid", {30'd0, m1_rvalid, m0_rvalid}, {30'd0, mon_ev});
        end
    end

    localparam logic [31:0] Z = 32'd0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;

        #3;
        chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        chk("rst_m0_err", {31'd0, m0_err}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
        chk("rst_mem_idx", mem_idx, 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drv(1, 0, 32'h10, Z, 0, 0, 0, Z, Z, 0);
        @(negedge clk);
        chk("pre_rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        @(posedge clk); #1;
        chk("pre_rst_rvalid", {31'd0, m0_rvalid}, 32'd1);
        drv(1, 1, 32'h20, 32'h11111111, 0, 1, 0, 32'h14, Z, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("async_rst_err", {31'd0, m0_err}, 32'd0);
        chk("async_rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
        @(posedge clk); #1;
        drv(1, 0, 32'h10, Z, 0, 1, 0, 32'h14, Z, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run = 1'b1;

        cycle(2'b01, 0, 32'h0, 0);
        drv(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, Z, Z, 0);
        cycle(2'b01, 1, 32'h0, 0);
        drv(0, 0, Z, Z, 0, 1, 0, 32'h10, Z, 0);
        cycle(2'b10, 0, 32'hDEADBEEF, 0);
        drv(0, 0, Z, Z, 0, 1, 1, 32'h14, 32'h12345678, 0);
        cycle(2'b10, 1, 32'h0, 0);

        drv(1, 0, 32'h10, Z, 0, 1, 0, 32'h14, Z, 0);
        cycle(2'b01, 0, 32'hDEADBEEF, 0);
        cycle(2'b10, 0, 32'h12345678, 0);
        cycle(2'b01, 0, 32'hDEADBEEF, 0);
        cycle(2'b10, 0, 32'h12345678, 0);

        drv(1, 0, 32'h10, Z, 0, 1, 0, 32'h14, Z, 1);
        cycle(2'b01, 0, 32'hDEADBEEF, 0);
        for (int i = 0; i < 4; i++) cycle(2'b10, 0, 32'h12345678, 0);
        cycle(2'b01, 0, 32'hDEADBEEF, 0);

        drv(1, 1, 32'h06, 32'hFFFFFFFF, 0, 0, 0, Z, Z, 0);
        cycle(2'b01, 0, 32'h0, 1);
        drv(1, 1, 32'h200, 32'hFFFFFFFF, 0, 0, 0, Z, Z, 0);
        cycle(2'b01, 0, 32'h0, 1);
        drv(1, 1, 32'h400, 32'hFFFFFFFF, 0, 0, 0, Z, Z, 0);
        cycle(2'b01, 0, 32'h0, 1);
        drv(1, 0, 32'h12, Z, 0, 0, 0, Z, Z, 0);
        cycle(2'b01, 0, 32'h0, 1);
        drv(1, 0, 32'h04, Z, 0, 0, 0, Z, Z, 0);
        cycle(2'b01, 0, 32'h0, 0);

        drv(1, 1, 32'h1FC, 32'hCAFEF00D, 0, 0, 0, Z, Z, 0);
        cycle(2'b01, 1, 32'h0, 0);
        drv(1, 0, 32'h1FC, Z, 0, 0, 0, Z, Z, 0);
        cycle(2'b01, 0, 32'hCAFEF00D, 0);
        drv(1, 0, 32'h00, Z, 0, 0, 0, Z, Z, 0);
        cycle(2'b01, 0, 32'h0, 0);

        drv(0, 0, Z, Z, 0, 1, 0, 32'h14, Z, 1);
        cycle(2'b10, 0, 32'h12345678, 0);
        drv(1, 0, 32'h10, Z, 0, 0, 0, Z, Z, 0);
        cycle(2'b01, 0, 32'hDEADBEEF, 0);

        drv(0, 0, Z, Z, 0, 0, 0, Z, Z, 0);
        for (int i = 0; i < 3; i++) cycle(2'b00, 0, 32'h0, 0);
        @(negedge clk);
        chk("idle_mem_idx", mem_idx, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
